// File: rtl/homo_decimator.sv
// homo_decimator: per-channel block-mean decimator with DC offset removal and output saturation.
// Define HOMO_ABS_RECT_EN to rectify (absolute value) input samples before the offset is removed.
module homo_decimator #(
    parameter int DATA_W     = 32,
    parameter int DECIM_LOG2 = 2,
    parameter int N_CH       = 1,
    parameter logic signed [DATA_W-1:0] OFFSET = DATA_W'(32'h0400_0000),
    localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [DATA_W-1:0] s_axis_data_tdata,
    input  logic              s_axis_data_tvalid,
    output logic              s_axis_data_tready,
    output logic [DATA_W-1:0] m_axis_data_tdata,
    output logic [CH_W-1:0]   m_axis_data_tuser,
    output logic              m_axis_data_tlast,
    output logic              m_axis_data_tvalid,
    input  logic              m_axis_data_tready,
    output logic              sat_pulse
);

    localparam int ACC_W = DATA_W + 1 + DECIM_LOG2;
    localparam int PH_W  = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'((1 << DECIM_LOG2) - 1);
    localparam logic [CH_W-1:0] CH_LAST = CH_W'(N_CH - 1);
    localparam logic signed [ACC_W-1:0] Y_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] Y_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    function automatic logic is_sat(input logic signed [ACC_W-1:0] v);
        return (v > Y_MAX) || (v < Y_MIN);
    endfunction

    function automatic logic [DATA_W-1:0] sat_data(input logic signed [ACC_W-1:0] v);
        if (v > Y_MAX)
            return Y_MAX[DATA_W-1:0];
        else if (v < Y_MIN)
            return Y_MIN[DATA_W-1:0];
        return v[DATA_W-1:0];
    endfunction

`ifdef HOMO_ABS_RECT_EN
    // The most-negative input has no positive twin, so it clamps to the largest positive value.
    function automatic logic signed [DATA_W-1:0] rect_abs(input logic signed [DATA_W-1:0] v);
        if (v == {1'b1, {(DATA_W-1){1'b0}}})
            return {1'b0, {(DATA_W-1){1'b1}}};
        return v[DATA_W-1] ? -v : v;
    endfunction
`endif

    logic signed [DATA_W-1:0] w_x_p0;
    logic signed [DATA_W:0]   w_d_p0;
    logic signed [ACC_W-1:0]  w_base_p0;
    logic signed [ACC_W-1:0]  w_sum_p0;
    logic signed [ACC_W-1:0]  w_mean_p0;
    logic                     w_acc_p0;
    logic                     w_done_p0;

    logic [CH_W-1:0]          r_ch;
    logic [PH_W-1:0]          r_phase;
    logic signed [ACC_W-1:0]  r_acc [N_CH];

    logic                     r_vld_p1;
    logic [DATA_W-1:0]        r_tdata_p1;
    logic [CH_W-1:0]          r_tuser_p1;
    logic                     r_tlast_p1;
    logic                     r_sat_p1;

    // Stage p0: offset removal, accumulate, mean and saturation on the accepted beat
`ifdef HOMO_ABS_RECT_EN
    assign w_x_p0 = rect_abs(s_axis_data_tdata);
`else
    assign w_x_p0 = s_axis_data_tdata;
`endif
    assign w_d_p0    = {w_x_p0[DATA_W-1], w_x_p0} - {OFFSET[DATA_W-1], OFFSET};
    assign w_base_p0 = (r_phase == '0) ? '0 : r_acc[r_ch];
    assign w_sum_p0  = w_base_p0 + ACC_W'(w_d_p0);
    assign w_mean_p0 = w_sum_p0 >>> DECIM_LOG2;

    assign s_axis_data_tready = !r_vld_p1 || m_axis_data_tready;
    assign w_acc_p0           = s_axis_data_tvalid && s_axis_data_tready;
    assign w_done_p0          = w_acc_p0 && (r_phase == PH_LAST);

    always_ff @(posedge aclk or posedge aresetn) begin
        if (aresetn) begin
            r_ch    <= '0;
            r_phase <= '0;
        end else if (w_acc_p0) begin
            if (r_ch == CH_LAST) begin
                r_ch    <= '0;
                r_phase <= (r_phase == PH_LAST) ? '0 : r_phase + 1'b1;
            end else begin
                r_ch <= r_ch + 1'b1;
            end
        end
    end

    // Phase 0 overwrites the slot, so stale sums after reset never leak into a block.
    always_ff @(posedge aclk) begin
        if (w_acc_p0)
            r_acc[r_ch] <= w_sum_p0;
    end

    // Stage p1: registered output beat, held while downstream stalls
    always_ff @(posedge aclk or posedge aresetn) begin
        if (aresetn) begin
            r_vld_p1   <= 1'b0;
            r_tdata_p1 <= '0;
            r_tuser_p1 <= '0;
            r_tlast_p1 <= 1'b0;
            r_sat_p1   <= 1'b0;
        end else begin
            r_sat_p1 <= w_done_p0 && is_sat(w_mean_p0);
            if (w_done_p0) begin
                r_vld_p1   <= 1'b1;
                r_tdata_p1 <= sat_data(w_mean_p0);
                r_tuser_p1 <= r_ch;
                r_tlast_p1 <= (r_ch == CH_LAST);
            end else if (m_axis_data_tready) begin
                r_vld_p1 <= 1'b0;
            end
        end
    end

    assign m_axis_data_tvalid = r_vld_p1;
    assign m_axis_data_tdata  = r_tdata_p1;
    assign m_axis_data_tuser  = r_tuser_p1;
    assign m_axis_data_tlast  = r_tlast_p1;
    assign sat_pulse          = r_sat_p1;

endmodule

// File: tb/tb_homo_decimator.sv
// tb_homo_decimator: directed bench for homo_decimator with a sample-level reference model.
// u_dut0 runs with one channel, u_dut1 with two interleaved channels; both use D = 4.
module tb_homo_decimator;

    localparam longint OFS = 64'h0400_0000;
    localparam int     D   = 4;

    typedef struct {
        logic [31:0] data;
        logic        user;
        logic        last;
        logic        sat;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0][31:0] s_data  = '0;
    logic [1:0]       s_valid = '0;
    logic [1:0]       m_ready = '1;
    wire  [1:0]       s_ready;
    wire  [1:0][31:0] m_data;
    wire  [1:0]       m_user;
    wire  [1:0]       m_last;
    wire  [1:0]       m_valid;
    wire  [1:0]       sat;

    int     n_checks = 0;
    int     n_fail   = 0;
    longint msum   [2][2];
    int     mcnt   [2][2];
    int     nacc   [2];
    exp_t   pend   [2];
    bit     pend_v [2];
    bit     shown  [2];
    logic [31:0] floor_vec [8];

    always #5 clk = ~clk;

    homo_decimator #(.DATA_W(32), .DECIM_LOG2(2), .N_CH(1)) u_dut0 (
        .aclk               (clk),
        .aresetn            (rst),
        .s_axis_data_tdata  (s_data[0]),
        .s_axis_data_tvalid (s_valid[0]),
        .s_axis_data_tready (s_ready[0]),
        .m_axis_data_tdata  (m_data[0]),
        .m_axis_data_tuser  (m_user[0]),
        .m_axis_data_tlast  (m_last[0]),
        .m_axis_data_tvalid (m_valid[0]),
        .m_axis_data_tready (m_ready[0]),
        .sat_pulse          (sat[0])
    );

    homo_decimator #(.DATA_W(32), .DECIM_LOG2(2), .N_CH(2)) u_dut1 (
        .aclk               (clk),
        .aresetn            (rst),
        .s_axis_data_tdata  (s_data[1]),
        .s_axis_data_tvalid (s_valid[1]),
        .s_axis_data_tready (s_ready[1]),
        .m_axis_data_tdata  (m_data[1]),
        .m_axis_data_tuser  (m_user[1]),
        .m_axis_data_tlast  (m_last[1]),
        .m_axis_data_tvalid (m_valid[1]),
        .m_axis_data_tready (m_ready[1]),
        .sat_pulse          (sat[1])
    );

    task automatic chk(input string name, input int k, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d got=%0h exp=%0h", name, k, got, exp);
        end
    endtask

    function automatic longint xval(input logic [31:0] v);
        longint s;
        s = longint'($signed(v));
`ifdef HOMO_ABS_RECT_EN
        if (s < 0) s = -s;
        if (s > 64'sd2147483647) s = 64'sd2147483647;
`endif
        return s;
    endfunction

    // Reference: sample k of the stream belongs to channel k mod N_CH; every D samples of a
    // channel produce floor(mean), clamped to the 32-bit signed range.
    task automatic model_accept(input int k, input logic [31:0] v);
        int     nch = (k == 0) ? 1 : 2;
        int     c   = nacc[k] % nch;
        longint y;
        nacc[k]++;
        msum[k][c] += xval(v) - OFS;
        mcnt[k][c]++;
        if (mcnt[k][c] == D) begin
            y = msum[k][c] / D;
            if ((msum[k][c] % D) != 0 && msum[k][c] < 0) y--;
            chk("overrun", k, {63'd0, pend_v[k]}, 64'd0);
            pend[k].sat  = (y > 64'sd2147483647) || (y < -64'sd2147483648);
            pend[k].data = (y > 64'sd2147483647) ? 32'h7FFF_FFFF :
                           (y < -64'sd2147483648) ? 32'h8000_0000 : y[31:0];
            pend[k].user = c[0];
            pend[k].last = (c == nch - 1);
            pend_v[k]    = 1'b1;
            shown[k]     = 1'b0;
            msum[k][c]   = 0;
            mcnt[k][c]   = 0;
        end
    endtask

    task automatic model_cycle(input int k);
        logic e_sat;
        if (rst) begin
            chk("rst_tvalid", k, m_valid[k], 0);
            chk("rst_tdata",  k, m_data[k],  0);
            chk("rst_tuser",  k, m_user[k],  0);
            chk("rst_tlast",  k, m_last[k],  0);
            chk("rst_sat",    k, sat[k],     0);
            chk("rst_tready", k, s_ready[k], 1);
            pend_v[k] = 1'b0;
            nacc[k]   = 0;
            for (int c = 0; c < 2; c++) begin
                msum[k][c] = 0;
                mcnt[k][c] = 0;
            end
            return;
        end
        chk("tvalid", k, m_valid[k], pend_v[k]);
        if (pend_v[k] && m_valid[k]) begin
            chk("tdata", k, m_data[k], pend[k].data);
            chk("tuser", k, m_user[k], pend[k].user);
            chk("tlast", k, m_last[k], pend[k].last);
        end
        e_sat = pend_v[k] && !shown[k] && pend[k].sat;
        chk("sat_pulse", k, sat[k], e_sat);
        if (pend_v[k]) shown[k] = 1'b1;
        chk("s_tready", k, s_ready[k], !pend_v[k] || m_ready[k]);
        if (pend_v[k] && m_ready[k]) pend_v[k] = 1'b0;
        if (s_valid[k] && s_ready[k]) model_accept(k, s_data[k]);
    endtask

    always @(negedge clk) begin
        model_cycle(0);
        model_cycle(1);
    end

    // Tasks start and end just after a rising edge.
    task automatic send(input int k, input logic [31:0] v);
        int n = 0;
        s_data[k]  = v;
        s_valid[k] = 1'b1;
        @(negedge clk);
        while (!s_ready[k] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", k, s_ready[k], 1);
        @(posedge clk);
        #1;
        s_valid[k] = 1'b0;
    endtask

    task automatic wait_out(input int k, input string name, input logic [31:0] e_data,
                            input logic e_user, input logic e_last, input logic e_sat);
        int n = 0;
        @(negedge clk);
        while (!m_valid[k] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_vld"},  k, m_valid[k], 1);
        chk({name, "_lat"},  k, n, 0);
        chk({name, "_data"}, k, m_data[k], e_data);
        chk({name, "_user"}, k, m_user[k], e_user);
        chk({name, "_last"}, k, m_last[k], e_last);
        chk({name, "_sat"},  k, sat[k], e_sat);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog dut0 got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        floor_vec = '{32'h0400_0001, 32'h0400_0005, 32'h0400_0002, 32'h0400_0005,
                      32'h0400_0003, 32'h0400_0005, 32'h03FF_FFF9, 32'h0400_0006};
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        repeat (4) send(0, 32'h0500_0000);
        wait_out(0, "mean4", 32'h0100_0000, 1'b0, 1'b1, 1'b0);

        repeat (4) send(0, 32'hFB00_0000);
`ifdef HOMO_ABS_RECT_EN
        wait_out(0, "neg_in", 32'h0100_0000, 1'b0, 1'b1, 1'b0);
`else
        wait_out(0, "neg_in", 32'hF700_0000, 1'b0, 1'b1, 1'b0);
`endif

        repeat (4) send(0, 32'h8000_0000);
`ifdef HOMO_ABS_RECT_EN
        wait_out(0, "most_neg", 32'h7BFF_FFFF, 1'b0, 1'b1, 1'b0);
`else
        wait_out(0, "most_neg", 32'h8000_0000, 1'b0, 1'b1, 1'b1);
`endif

        for (int i = 0; i < 7; i++) send(1, (i % 2 == 0) ? 32'h0400_0010 : 32'h0400_0020);
        wait_out(1, "ch0", 32'h0000_0010, 1'b0, 1'b0, 1'b0);
        send(1, 32'h0400_0020);
        wait_out(1, "ch1", 32'h0000_0020, 1'b1, 1'b1, 1'b0);

        for (int i = 0; i < 7; i++) send(1, floor_vec[i]);
        wait_out(1, "floor_ch0", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        send(1, floor_vec[7]);
        wait_out(1, "floor_ch1", 32'h0000_0005, 1'b1, 1'b1, 1'b0);

        m_ready[0] = 1'b0;
        repeat (4) send(0, 32'h0500_0000);
        wait_out(0, "bp_first", 32'h0100_0000, 1'b0, 1'b1, 1'b0);
        s_data[0]  = 32'h0500_0000;
        s_valid[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_vld",  0, m_valid[0], 1);
            chk("bp_hold_data", 0, m_data[0], 32'h0100_0000);
            chk("bp_s_tready",  0, s_ready[0], 0);
        end
        @(posedge clk);
        #1 m_ready[0] = 1'b1;
        @(negedge clk);
        chk("bp_release_data", 0, m_data[0], 32'h0100_0000);
        @(posedge clk);
        #1 s_valid[0] = 1'b0;
        repeat (3) send(0, 32'h0500_0000);
        wait_out(0, "bp_next", 32'h0100_0000, 1'b0, 1'b1, 1'b0);

        fork
            for (int i = 0; i < 16; i++) send(1, 32'h0400_0000 + 32'(i * 977) - 32'd5000);
            for (int c = 0; c < 60; c++) begin
                m_ready[1] = (c % 3 != 0);
                @(posedge clk);
                #1;
            end
        join
        m_ready[1] = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        repeat (2) send(0, 32'h7000_0000);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_vld", 0, m_valid[0], 0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) send(0, 32'h0500_0000);
        wait_out(0, "post_rst", 32'h0100_0000, 1'b0, 1'b1, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        chk("drained", 0, pend_v[0], 0);
        chk("drained", 1, pend_v[1], 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/homo_decimator.md
HOMO_DECIMATOR -- requirements
Module: homo_decimator

Interface
REQ-001 SHALL have parameter DATA_W, default 32, the sample width (signed two's complement).
REQ-002 SHALL have parameter DECIM_LOG2, default 2, giving a decimation factor D = 2^DECIM_LOG2 (1..8 supported).
REQ-003 SHALL have parameter N_CH, default 1, the number of time-interleaved channels (1..16); CH_W = max(1, clog2(N_CH)).
REQ-004 SHALL have parameter OFFSET, default 32'h0400_0000, a signed DATA_W offset subtracted from every sample (exp-output DC bias).
REQ-005 SHALL have port aclk  input  1  the single clock; all logic on its rising edge.
REQ-006 SHALL have port aresetn  input  1  asynchronous active-high reset (1 = in reset).
REQ-007 SHALL have port s_axis_data_tdata  input  DATA_W  input sample.
REQ-008 SHALL have port s_axis_data_tvalid  input  1  input sample valid.
REQ-009 SHALL have port s_axis_data_tready  output  1  block accepts a sample this cycle.
REQ-010 SHALL have port m_axis_data_tdata  output  DATA_W  decimated, offset-removed mean.
REQ-011 SHALL have port m_axis_data_tuser  output  CH_W  channel index of the output beat.
REQ-012 SHALL have port m_axis_data_tlast  output  1  high on the output beat of channel N_CH-1.
REQ-013 SHALL have port m_axis_data_tvalid  output  1  output beat valid.
REQ-014 SHALL have port m_axis_data_tready  input  1  downstream accepts output.
REQ-015 SHALL have port sat_pulse  output  1  one-cycle pulse when an output beat is saturated.

Function
REQ-016 An input beat SHALL be accepted only on a cycle where s_axis_data_tvalid and s_axis_data_tready are both high.
REQ-017 s_axis_data_tready SHALL equal (!m_axis_data_tvalid | m_axis_data_tready), combinationally.
REQ-018 Each accepted sample x SHALL form d = x - OFFSET at DATA_W+1 bits, no wrap.
REQ-019 A channel counter ch SHALL start at 0, step by 1 per accepted beat, and wrap from N_CH-1 to 0.
REQ-020 A phase counter SHALL start at 0, step by 1 whenever ch wraps, and wrap from D-1 to 0.
REQ-021 Per-channel accumulator acc[ch] (DATA_W+1+DECIM_LOG2 bits) SHALL load d when phase is 0 and add d otherwise.
REQ-022 On an accepted beat with phase D-1, the block SHALL compute y = (acc[ch]+d) >>> DECIM_LOG2 (arithmetic shift, floor).
REQ-023 y SHALL be saturated to the signed DATA_W range, and sat_pulse SHALL be high for the cycle the saturated beat first becomes valid.
REQ-024 y, ch and (ch==N_CH-1) SHALL be registered into tdata/tuser/tlast with m_axis_data_tvalid high on the next cycle (latency 1).
REQ-025 While m_axis_data_tvalid=1 and m_axis_data_tready=0, tdata/tuser/tlast/tvalid SHALL hold stable.
REQ-026 m_axis_data_tvalid SHALL clear after a handshake unless a new result is registered in the same cycle (back-to-back output allowed).
REQ-027 No input sample SHALL be dropped or double-counted under any backpressure pattern.

Reset
REQ-028 While aresetn=1, m_axis_data_tvalid, tdata, tuser, tlast, sat_pulse, ch and phase SHALL be 0 asynchronously; s_axis_data_tready SHALL be 1.
REQ-029 Reset mid-block SHALL discard partial accumulations; the first post-reset sample is channel 0, phase 0 (accumulators need no reset).

Configuration
REQ-030 With macro HOMO_ABS_RECT_EN defined, x SHALL be |s_axis_data_tdata| before offset, the most-negative input mapping to the most-positive value.
REQ-031 Without HOMO_ABS_RECT_EN, x SHALL be s_axis_data_tdata unchanged (signed), and no rectifier logic SHALL be present.

Verification (DATA_W=32, DECIM_LOG2=2, OFFSET=0x0400_0000 unless stated)
REQ-032 N_CH=1, four beats 0x0500_0000 -> one output 0x0100_0000, tuser 0, tlast 1, valid one cycle after 4th accept.
REQ-033 Macro on, four beats 0xFB00_0000 (-0x0500_0000) -> 0x0100_0000; macro off -> 0xF700_0000.
REQ-034 N_CH=2, eight beats alternating 0x0400_0010/0x0400_0020 -> 0x10 (tuser 0, tlast 0) then 0x20 (tuser 1, tlast 1).
REQ-035 Same stimulus as REQ-032 with tready held low 5 cycles -> output held stable, s_axis_data_tready low, result unchanged after release.
REQ-036 Macro off, four beats 0x8000_0000 -> output 0x8000_0000 with sat_pulse high for one cycle.
REQ-037 Two beats 0x7000_0000, reset pulse, then four beats 0x0500_0000 -> single output 0x0100_0000.
